pipelined_adder: RTL and testbench

Parametrised, segmented, pipelined two's-complement adder/subtractor. It replaces the single-cycle ripple adder wherever wide operands or back-to-back arithmetic would limit clock frequency. The adder splits the operands into SEG_WIDTH-bit ripple segments, adds one segment per pipeline stage, and registers the carry between stages. A valid/ready handshake on both sides gives throughput of one operation per cycle with full backpressure.

---
 rtl/pipelined_adder.sv | 103 ++++++++++
 tb/tb_pipelined_adder.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipelined_adder.sv
// Segmented, pipelined two's-complement adder/subtractor: one SEG_WIDTH-bit ripple
// segment per stage, inter-stage carry registered, valid/ready with a global stall.
module pipelined_adder #(
    parameter int WIDTH     = 16,
    parameter int SEG_WIDTH = 4
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    input  logic             Sub,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] Sum,
    output logic             CO,
    output logic             OV,
    output logic             out_valid,
    input  logic             out_ready
);
    localparam int STAGES = (SEG_WIDTH >= 1 && WIDTH / SEG_WIDTH >= 1) ? WIDTH / SEG_WIDTH : 1;
    localparam int LAST   = STAGES - 1;

    if ((SEG_WIDTH < 1) || (SEG_WIDTH > WIDTH) || ((WIDTH % SEG_WIDTH) != 0)) begin : g_param_check
        $error("pipelined_adder: WIDTH must be a positive multiple of SEG_WIDTH");
    end

    function automatic logic [SEG_WIDTH:0] seg_add(
        input logic [SEG_WIDTH-1:0] x,
        input logic [SEG_WIDTH-1:0] y,
        input logic                 c
    );
        return {1'b0, x} + {1'b0, y} + {{SEG_WIDTH{1'b0}}, c};
    endfunction

    // Stage k register: r_x holds finished sums in segments 0..k and raw A above;
    // r_y holds the (possibly inverted) B operand; r_c is the carry out of segment k.
    logic [WIDTH-1:0] r_x   [STAGES];
    logic [WIDTH-1:0] r_y   [STAGES];
    logic             r_c   [STAGES];
    logic             r_vld [STAGES];
    logic             r_ov;

    logic [WIDTH-1:0]   w_xin  [STAGES];
    logic [WIDTH-1:0]   w_yin  [STAGES];
    logic               w_cin  [STAGES];
    logic [SEG_WIDTH:0] w_seg  [STAGES];
    logic [WIDTH-1:0]   w_xout [STAGES];
    logic               w_ov;
    logic               w_advance;

    assign w_advance = !r_vld[LAST] || out_ready;
    assign in_ready  = w_advance;

    always_comb begin
        w_xin[0] = A;
        w_yin[0] = Sub ? ~B : B;
        w_cin[0] = Sub | Cin;
        for (int k = 1; k < STAGES; k++) begin
            w_xin[k] = r_x[k-1];
            w_yin[k] = r_y[k-1];
            w_cin[k] = r_c[k-1];
        end
        for (int k = 0; k < STAGES; k++) begin
            w_seg[k]  = seg_add(w_xin[k][k*SEG_WIDTH +: SEG_WIDTH],
                                w_yin[k][k*SEG_WIDTH +: SEG_WIDTH], w_cin[k]);
            w_xout[k] = w_xin[k];
            w_xout[k][k*SEG_WIDTH +: SEG_WIDTH] = w_seg[k][SEG_WIDTH-1:0];
        end
    end

    // Carry into the MSB is recovered from the MSB's sum and operand bits.
    assign w_ov = w_xin[LAST][WIDTH-1] ^ w_yin[LAST][WIDTH-1]
                ^ w_seg[LAST][SEG_WIDTH-1] ^ w_seg[LAST][SEG_WIDTH];

    always_ff @(posedge Clk) begin
        if (Reset) begin
            for (int k = 0; k < STAGES; k++) begin
                r_vld[k] <= 1'b0;
            end
            r_x[LAST] <= '0;
            r_c[LAST] <= 1'b0;
            r_ov      <= 1'b0;
        end else if (w_advance) begin
            r_vld[0] <= in_valid;
            for (int k = 1; k < STAGES; k++) begin
                r_vld[k] <= r_vld[k-1];
            end
            for (int k = 0; k < STAGES; k++) begin
                r_x[k] <= w_xout[k];
                r_y[k] <= w_yin[k];
                r_c[k] <= w_seg[k][SEG_WIDTH];
            end
            r_ov <= w_ov;
        end
    end

    assign Sum       = r_x[LAST];
    assign CO        = r_c[LAST];
    assign OV        = r_ov;
    assign out_valid = r_vld[LAST];

endmodule

// File: tb/tb_pipelined_adder.sv
// Bench for pipelined_adder: three instances (16/4, 8/8, 32/4) driven from shared stimulus,
// directed vector table plus stall, mid-stream reset and random streaming sequences.
module tb_pipelined_adder;

    typedef struct packed {
        logic [31:0] s;
        logic        co;
        logic        ov;
    } exp_t;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        sub;
        logic        cin;
        logic [15:0] es;
        logic        eco;
        logic        eov;
    } vec_t;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        cin;
    logic        sub;
    logic        out_ready;
    logic [31:0] a_drv;
    logic [31:0] b_drv;

    logic [15:0] sum16;
    logic [7:0]  sum8;
    logic [31:0] sum32;
    logic        ir0, ir1, ir2, vld0, vld1, vld2, co0, co1, co2, ov0, ov1, ov2;

    logic [31:0] o_sum [3];
    logic        o_ir  [3];
    logic        o_vld [3];
    logic        o_co  [3];
    logic        o_ov  [3];

    int   checks;
    int   failures;
    int   W   [3];
    int   LAT [3];
    exp_t mem [3][1024];
    int   wr  [3];
    int   rd  [3];
    int   popped [3];
    logic held_v [3];
    exp_t held_e [3];
    logic acc0;
    vec_t tbl [10];

    pipelined_adder #(.WIDTH(16), .SEG_WIDTH(4)) dut16 (
        .Clk(clk), .Reset(rst), .A(a_drv[15:0]), .B(b_drv[15:0]), .Cin(cin), .Sub(sub),
        .in_valid(in_valid), .in_ready(ir0), .Sum(sum16), .CO(co0), .OV(ov0),
        .out_valid(vld0), .out_ready(out_ready)
    );

    pipelined_adder #(.WIDTH(8), .SEG_WIDTH(8)) dut8 (
        .Clk(clk), .Reset(rst), .A(a_drv[7:0]), .B(b_drv[7:0]), .Cin(cin), .Sub(sub),
        .in_valid(in_valid), .in_ready(ir1), .Sum(sum8), .CO(co1), .OV(ov1),
        .out_valid(vld1), .out_ready(out_ready)
    );

    pipelined_adder #(.WIDTH(32), .SEG_WIDTH(4)) dut32 (
        .Clk(clk), .Reset(rst), .A(a_drv), .B(b_drv), .Cin(cin), .Sub(sub),
        .in_valid(in_valid), .in_ready(ir2), .Sum(sum32), .CO(co2), .OV(ov2),
        .out_valid(vld2), .out_ready(out_ready)
    );

    assign o_sum[0] = {16'd0, sum16};
    assign o_sum[1] = {24'd0, sum8};
    assign o_sum[2] = sum32;
    assign o_ir[0]  = ir0;
    assign o_ir[1]  = ir1;
    assign o_ir[2]  = ir2;
    assign o_vld[0] = vld0;
    assign o_vld[1] = vld1;
    assign o_vld[2] = vld2;
    assign o_co[0]  = co0;
    assign o_co[1]  = co1;
    assign o_co[2]  = co2;
    assign o_ov[0]  = ov0;
    assign o_ov[1]  = ov1;
    assign o_ov[2]  = ov2;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", nm, act, req);
        end
    endtask

    // Reference: plain wide addition, overflow from the operand/result sign rule.
    task automatic model(input logic [31:0] a, input logic [31:0] b, input logic s,
                         input logic c, input int w, output exp_t e);
        logic [32:0] full;
        logic [31:0] m, aa, bb;
        m    = (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
        aa   = a & m;
        bb   = (s ? ~b : b) & m;
        full = {1'b0, aa} + {1'b0, bb} + {32'd0, (s | c)};
        e.s  = full[31:0] & m;
        e.co = full[w];
        e.ov = (aa[w-1] == bb[w-1]) && (e.s[w-1] != aa[w-1]);
    endtask

    // One clock cycle: drive after the rising edge, sample and score at the falling edge.
    task automatic step(input logic rv, input logic v, input logic [31:0] a, input logic [31:0] b,
                        input logic s, input logic c, input logic ordy);
        exp_t e;
        @(posedge clk);
        #1;
        rst = rv; in_valid = v; a_drv = a; b_drv = b; sub = s; cin = c; out_ready = ordy;
        @(negedge clk);
        acc0 = 1'b0;
        for (int d = 0; d < 3; d++) begin
            if (rv) begin
                rd[d]     = wr[d];
                held_v[d] = 1'b0;
            end else begin
                chk($sformatf("in_ready_rule[%0d]", d), 32'(o_ir[d]), 32'(!o_vld[d] || ordy));
                if (held_v[d]) begin
                    chk($sformatf("stall_vld[%0d]", d), 32'(o_vld[d]), 32'd1);
                    chk($sformatf("stall_sum[%0d]", d), o_sum[d], held_e[d].s);
                    chk($sformatf("stall_co[%0d]", d), 32'(o_co[d]), 32'(held_e[d].co));
                    chk($sformatf("stall_ov[%0d]", d), 32'(o_ov[d]), 32'(held_e[d].ov));
                end
                if (o_vld[d] && ordy) begin
                    if (rd[d] == wr[d]) begin
                        chk($sformatf("no_extra_out[%0d]", d), 32'(o_vld[d]), 32'd0);
                    end else begin
                        e = mem[d][rd[d] % 1024];
                        rd[d]++;
                        popped[d]++;
                        chk($sformatf("sb_sum[%0d]", d), o_sum[d], e.s);
                        chk($sformatf("sb_co[%0d]", d), 32'(o_co[d]), 32'(e.co));
                        chk($sformatf("sb_ov[%0d]", d), 32'(o_ov[d]), 32'(e.ov));
                    end
                end
                held_v[d]    = o_vld[d] && !ordy;
                held_e[d].s  = o_sum[d];
                held_e[d].co = o_co[d];
                held_e[d].ov = o_ov[d];
                if (v && o_ir[d]) begin
                    model(a, b, s, c, W[d], e);
                    mem[d][wr[d] % 1024] = e;
                    wr[d]++;
                    if (d == 0) acc0 = 1'b1;
                end
            end
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic push(input vec_t t, input logic ordy);
        step(1'b0, 1'b1, t.a, t.b, t.sub, t.cin, ordy);
    endtask

    initial begin
        logic        v, ordy;
        logic [31:0] ca, cb;
        logic        cs, cc;
        int          sent, guard, base;

        checks = 0; failures = 0;
        W   = '{16, 8, 32};
        LAT = '{4, 1, 8};
        for (int d = 0; d < 3; d++) begin
            wr[d] = 0; rd[d] = 0; popped[d] = 0; held_v[d] = 1'b0;
        end
        rst = 1'b0; in_valid = 1'b0; cin = 1'b0; sub = 1'b0; out_ready = 1'b0;
        a_drv = '0; b_drv = '0;

        //                a             b            sub   cin   Sum16     CO    OV
        tbl[0] = '{32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
        tbl[1] = '{32'h0000_7FFF, 32'h0000_0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
        tbl[2] = '{32'h0000_0005, 32'h0000_0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0};
        tbl[3] = '{32'h0000_8000, 32'h0000_0001, 1'b1, 1'b0, 16'h7FFF, 1'b1, 1'b1};
        tbl[4] = '{32'h0000_1234, 32'h0000_4321, 1'b0, 1'b1, 16'h5556, 1'b0, 1'b0};
        tbl[5] = '{32'h0000_0F0F, 32'h0000_00F1, 1'b0, 1'b0, 16'h1000, 1'b0, 1'b0};
        tbl[6] = '{32'h0000_8000, 32'h0000_8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1};
        tbl[7] = '{32'h0000_0003, 32'h0000_0003, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0};
        tbl[8] = '{32'h0000_0000, 32'h0000_0000, 1'b0, 1'b1, 16'h0001, 1'b0, 1'b0};
        tbl[9] = '{32'h0000_7FFF, 32'h0000_FFFF, 1'b1, 1'b0, 16'h8000, 1'b0, 1'b1};

        // Reset values, with out_ready low so in_ready=1 comes only from out_valid=0.
        step(1'b1, 1'b1, 32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0);
        for (int d = 0; d < 3; d++) begin
            chk($sformatf("reset_vld[%0d]", d), 32'(o_vld[d]), 32'd0);
            chk($sformatf("reset_sum[%0d]", d), o_sum[d], 32'd0);
            chk($sformatf("reset_co[%0d]", d), 32'(o_co[d]), 32'd0);
            chk($sformatf("reset_ov[%0d]", d), 32'(o_ov[d]), 32'd0);
            chk($sformatf("reset_in_ready[%0d]", d), 32'(o_ir[d]), 32'd1);
        end

        // Directed table, back-to-back: exact latency per width and hand-computed 16-bit results.
        for (int i = 0; i < 18; i++) begin
            if (i < 10) push(tbl[i], 1'b1);
            else idle(1);
            for (int d = 0; d < 3; d++)
                chk($sformatf("tbl_vld[%0d] i=%0d", d, i), 32'(o_vld[d]),
                    32'((i >= LAT[d]) && (i - LAT[d] < 10)));
            if (i >= 4 && i < 14) begin
                chk($sformatf("tbl_sum v%0d", i - 4), o_sum[0], {16'd0, tbl[i-4].es});
                chk($sformatf("tbl_co v%0d", i - 4), 32'(o_co[0]), 32'(tbl[i-4].eco));
                chk($sformatf("tbl_ov v%0d", i - 4), 32'(o_ov[0]), 32'(tbl[i-4].eov));
            end
        end
        idle(4);

        // Full-pipeline stall: four beats fill the 16-bit pipe, five stall cycles, then release.
        for (int j = 0; j < 4; j++) begin
            push(tbl[j], 1'b0);
            chk($sformatf("fill_vld j=%0d", j), 32'(o_vld[0]), 32'd0);
        end
        for (int k = 0; k < 5; k++) begin
            push(tbl[4], 1'b0);
            chk($sformatf("stall_in_ready k=%0d", k), 32'(o_ir[0]), 32'd0);
            chk($sformatf("stall_out_valid k=%0d", k), 32'(o_vld[0]), 32'd1);
            chk($sformatf("stall_hold_sum k=%0d", k), o_sum[0], {16'd0, tbl[0].es});
        end
        for (int r = 0; r < 5; r++) begin
            step(1'b0, r == 0, tbl[4].a, tbl[4].b, tbl[4].sub, tbl[4].cin, 1'b1);
            chk($sformatf("release_vld r=%0d", r), 32'(o_vld[0]), 32'd1);
            chk($sformatf("release_sum r=%0d", r), o_sum[0], {16'd0, tbl[r].es});
        end
        idle(10);

        // Reset with three beats in flight; a beat offered during reset must not be taken.
        for (int j = 5; j < 8; j++) push(tbl[j], 1'b1);
        step(1'b1, 1'b1, tbl[8].a, tbl[8].b, tbl[8].sub, tbl[8].cin, 1'b1);
        for (int i = 0; i < 10; i++) begin
            idle(1);
            for (int d = 0; d < 3; d++)
                chk($sformatf("post_reset_vld[%0d] i=%0d", d, i), 32'(o_vld[d]), 32'd0);
        end
        push(tbl[9], 1'b1);
        for (int i = 1; i <= 6; i++) begin
            idle(1);
            chk($sformatf("post_reset_latency i=%0d", i), 32'(o_vld[0]), 32'(i == 4));
            if (i == 4) chk("post_reset_sum", o_sum[0], {16'd0, tbl[9].es});
        end
        idle(10);

        // Random streaming: in_valid ~70%, out_ready ~50%.
        sent = 0; guard = 0; base = popped[0];
        ca = $urandom; cb = $urandom; cs = 1'($urandom_range(0, 1)); cc = 1'($urandom_range(0, 1));
        while ((sent < 100 || rd[0] != wr[0]) && guard < 3000) begin
            v    = (sent < 100) && ($urandom_range(0, 9) < 7);
            ordy = 1'($urandom_range(0, 1));
            step(1'b0, v, ca, cb, cs, cc, ordy);
            if (acc0) begin
                sent++;
                ca = $urandom; cb = $urandom;
                cs = 1'($urandom_range(0, 1)); cc = 1'($urandom_range(0, 1));
            end
            guard++;
        end
        chk("stream_accepted", 32'(sent), 32'd100);
        chk("stream_emitted", 32'(popped[0] - base), 32'd100);
        idle(12);
        for (int d = 0; d < 3; d++)
            chk($sformatf("drained[%0d]", d), 32'(rd[d]), 32'(wr[d]));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
